// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: shares the single-port dm SRAM between the MEM-stage
// core port and the host load/dump port, with a starvation guarantee for the host.
module dm_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              core_req,
    input  logic [3:0]        core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              host_valid,
    input  logic [3:0]        host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [15:0]       stall_cycles
);

    typedef enum logic [1:0] {RD_NONE, RD_CORE, RD_HOST} rd_owner_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic      host_grant;
    logic      core_grant;
    logic [3:0] starve_cnt;
    rd_owner_t rd_owner;
    rd_owner_t rd_owner_nxt;

    // Grants are suppressed during reset so nothing reaches the SRAM.
    always_comb begin
        host_grant = !rst && host_valid && (halt || !core_req || starve_cnt == STARVE_LIM);
        core_grant = !rst && core_req && !host_grant;
    end

    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 4'h0;
        sram_addr  = core_addr;
        sram_wdata = core_wdata;
        if (host_grant) begin
            sram_en    = 1'b1;
            sram_we    = host_we;
            sram_addr  = host_addr;
            sram_wdata = host_wdata;
        end else if (core_grant) begin
            sram_en    = 1'b1;
            sram_we    = core_we;
        end
    end

    assign core_stall = !rst && core_req && !core_grant;
    assign host_ready = host_grant;

    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= 4'd0;
        else if (host_grant || !host_valid)
            starve_cnt <= 4'd0;
        else if (starve_cnt != STARVE_LIM)
            starve_cnt <= starve_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= 16'd0;
        else if (core_stall && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
    end

    // Read-ownership tag: who the SRAM output belongs to this cycle.
    always_ff @(posedge clk) begin
        if (rst)
            rd_owner <= RD_NONE;
        else
            rd_owner <= rd_owner_nxt;
    end

    always_comb begin
        rd_owner_nxt = RD_NONE;
        if (host_grant && host_we == 4'h0)
            rd_owner_nxt = RD_HOST;
        else if (core_grant && core_we == 4'h0)
            rd_owner_nxt = RD_CORE;
    end

    // A read in flight when reset arrives never reports to the host.
    always_comb begin
        host_rvalid = (rd_owner == RD_HOST) && !rst;
        host_rdata  = sram_rdata;
        core_rdata  = sram_rdata;
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural SRAM and a read-response
// scoreboard keyed on the cycle each response is due.
module tb_dm_port_arbiter;

    logic        clk, rst, halt;
    logic        core_req;
    logic [3:0]  core_we;
    logic [15:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_stall;
    logic [31:0] core_rdata;
    logic        host_valid;
    logic [3:0]  host_we;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_ready, host_rvalid;
    logic [31:0] host_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [15:0] stall_cycles;

    dm_port_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_stall(core_stall), .core_rdata(core_rdata),
        .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ready(host_ready), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous single-port SRAM with byte enables.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we == 4'h0)
                sram_rdata <= mem[sram_addr[9:2]];
            else
                for (int b = 0; b < 4; b++)
                    if (sram_we[b]) mem[sram_addr[9:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
        end
    end

    function automatic logic [31:0] pre(input int i);
        return 32'hA500_0000 + 32'(i);
    endfunction

    typedef struct {
        logic        host;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_assert;
    int   n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic host, input logic [31:0] data);
        exp_t e;
        e.host = host;
        e.data = data;
        e.due  = cyc + 1;
        q.push_back(e);
    endtask

    task automatic check_resp();
        logic exp_v;
        exp_v = (q.size() > 0 && q[0].due == cyc && q[0].host);
        chk("host_rvalid", 32'(host_rvalid), 32'(exp_v));
        if (q.size() > 0 && q[0].due == cyc) begin
            if (q[0].host) chk("host_rdata", host_rdata, q[0].data);
            else           chk("core_rdata", core_rdata, q[0].data);
            void'(q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_resp();
    endtask

    task automatic idle();
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        host_valid = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    endtask

    initial begin
        n_assert = 0; n_fail = 0; cyc = 0;
        for (int i = 0; i < 256; i++) mem[i] = pre(i);
        sram_rdata = 32'h0;
        halt = 0;
        idle();

        // Reset held two cycles with both ports requesting.
        rst = 1; core_req = 1; host_valid = 1; host_addr = 16'h0020;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("rst_sram_en", 32'(sram_en), 32'd0);
            chk("rst_host_ready", 32'(host_ready), 32'd0);
            chk("rst_core_stall", 32'(core_stall), 32'd0);
            tick();
        end
        rst = 0; idle();
        #1;
        chk("rst_stall_cycles", 32'(stall_cycles), 32'd0);
        chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);

        // Core-only write then read back.
        core_req = 1; core_we = 4'hF; core_addr = 16'h0010; core_wdata = 32'hDEADBEEF;
        #1;
        chk("core_wr_stall", 32'(core_stall), 32'd0);
        chk("core_wr_sram_we", 32'(sram_we), 32'hF);
        tick();
        core_we = 4'h0;
        #1;
        chk("core_rd_stall", 32'(core_stall), 32'd0);
        chk("core_rd_sram_en", 32'(sram_en), 32'd1);
        push(1'b0, 32'hDEADBEEF);
        tick();
        idle();
        tick();

        // Starvation: host forced in on its fifth waiting cycle.
        core_req = 1; core_we = 4'hF; core_addr = 16'h0080; core_wdata = 32'h0BADF00D;
        host_valid = 1; host_we = 4'h0; host_addr = 16'h0020;
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk("starve_ready", 32'(host_ready), (k == 5) ? 32'd1 : 32'd0);
            chk("starve_core_stall", 32'(core_stall), (k == 5) ? 32'd1 : 32'd0);
            if (k == 5) push(1'b1, pre(8));
            tick();
        end
        host_valid = 0;
        #1;
        chk("starve_stall_after", 32'(core_stall), 32'd0);
        chk("starve_stall_cycles", 32'(stall_cycles), 32'd1);
        idle();
        tick();

        // Halt dump: ten back-to-back host reads, core stalled throughout.
        halt = 1; core_req = 1; core_addr = 16'h0200;
        host_valid = 1; host_we = 4'h0;
        for (int i = 0; i < 10; i++) begin
            host_addr = 16'(i * 4);
            #1;
            chk("halt_core_stall", 32'(core_stall), 32'd1);
            chk("halt_host_ready", 32'(host_ready), 32'd1);
            push(1'b1, (i == 4) ? 32'hDEADBEEF : pre(i));
            tick();
        end
        halt = 0; idle();
        tick();
        chk("halt_stall_cycles", 32'(stall_cycles), 32'd11);

        // Byte-write merge: core full write, host byte-0 write, host read.
        core_req = 1; core_we = 4'hF; core_addr = 16'h0040; core_wdata = 32'h11223344;
        tick();
        idle();
        host_valid = 1; host_we = 4'b0001; host_addr = 16'h0040; host_wdata = 32'h000000AA;
        #1;
        chk("merge_wr_ready", 32'(host_ready), 32'd1);
        tick();
        host_we = 4'h0;
        #1;
        push(1'b1, 32'h112233AA);
        tick();
        idle();
        tick();

        // Reset arriving the cycle after a host read grant suppresses its response.
        host_valid = 1; host_we = 4'h0; host_addr = 16'h0044;
        #1;
        chk("rstrd_ready", 32'(host_ready), 32'd1);
        @(posedge clk);
        #1;
        cyc++;
        rst = 1; idle();
        #1;
        chk("rstrd_no_rvalid", 32'(host_rvalid), 32'd0);
        tick();
        rst = 0;
        #1;
        chk("rstrd_stall_cycles", 32'(stall_cycles), 32'd0);
        tick();

        // Starvation counter restarts from zero after reset.
        core_req = 1; core_we = 4'hF; core_addr = 16'h0080; core_wdata = 32'h0;
        host_valid = 1; host_we = 4'h0; host_addr = 16'h0048;
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk("post_rst_ready", 32'(host_ready), (k == 5) ? 32'd1 : 32'd0);
            if (k == 5) push(1'b1, pre(18));
            tick();
        end
        idle();
        tick();
        tick();

        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
